// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// states, opcode/funct values, ALU codes, mux selects, trap causes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  localparam logic [1:0] SA_PC    = 2'd0;
  localparam logic [1:0] SA_RS    = 2'd1;
  localparam logic [1:0] SA_SHAMT = 2'd2;

  localparam logic [1:0] SB_RT   = 2'd0;
  localparam logic [1:0] SB_FOUR = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_IMM2 = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] PCS_ALU = 2'd0;
  localparam logic [1:0] PCS_OUT = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;
  localparam logic [1:0] PCS_RS  = 2'd3;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILL_OP  = 2'd1;
  localparam logic [1:0] TC_ILL_FN  = 2'd2;
  localparam logic [1:0] TC_TIMEOUT = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// R-type funct decoder: ALU operation, shift/jr flags and
// illegal-funct detection.
module alu_op_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       is_shift_o,
  output logic       is_jr_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    is_shift_o = 1'b0;
    is_jr_o    = 1'b0;
    illegal_o  = 1'b0;
    unique case (funct_i)
      FN_ADD: alu_ctrl_o = ALU_ADD;
      FN_SUB: alu_ctrl_o = ALU_SUB;
      FN_AND: alu_ctrl_o = ALU_AND;
      FN_OR:  alu_ctrl_o = ALU_OR;
      FN_SLT: alu_ctrl_o = ALU_SLT;
      FN_SLL: begin
        alu_ctrl_o = ALU_SLL;
        is_shift_o = 1'b1;
      end
      FN_SRL: begin
        alu_ctrl_o = ALU_SRL;
        is_shift_o = 1'b1;
      end
      FN_JR:  is_jr_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle MIPS datapath: sequences shared
// ALU/memory, handles memory wait/timeout, traps, counts retires.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             alu_neg_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [1:0]       pc_src_o,
  output logic [3:0]       state_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  state_e             state_q, state_d;
  logic [1:0]         cause_q, cause_d;
  logic [31:0]        wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic [3:0] fn_alu;
  logic       fn_shift;
  logic       fn_jr;
  logic       fn_ill;
  logic       mem_wait;
  logic       timeout;
  logic       taken;

  alu_op_decode u_fn (
    .funct_i    (funct_i),
    .alu_ctrl_o (fn_alu),
    .is_shift_o (fn_shift),
    .is_jr_o    (fn_jr),
    .illegal_o  (fn_ill)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      cause_q   <= TC_NONE;
      wcnt_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      wcnt_q    <= wcnt_d;
      instret_q <= instret_d;
    end
  end

  assign mem_wait = (state_q == S_FETCH) ||
                    (state_q == S_MEMRD) ||
                    (state_q == S_MEMWR);
  // ready wins: timeout only fires on a not-ready cycle
  assign timeout = (MEM_TIMEOUT != 0) && mem_wait &&
                   !mem_ready_i &&
                   (wcnt_q == MEM_TIMEOUT - 1);

  always_comb begin
    unique case (opcode_i[1:0])
      2'd0:    taken = zero_i;
      2'd1:    taken = ~zero_i;
      2'd2:    taken = zero_i | alu_neg_i;
      default: taken = ~(zero_i | alu_neg_i);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode_i)
          OP_RTYPE: state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ, OP_BNE,
          OP_BLEZ, OP_BGTZ: state_d = S_BRANCH;
          OP_J, OP_JAL: state_d = S_JUMP;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = TC_ILL_OP;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_EXEC: begin
        if (fn_ill) begin
          state_d = S_TRAP;
          cause_d = TC_ILL_FN;
        end else if (fn_jr) begin
          state_d = S_JR;
        end else begin
          state_d = S_RWB;
        end
      end
      S_IEXEC: state_d = S_IWB;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = TC_TIMEOUT;
    end
  end

  always_comb begin
    wcnt_d = '0;
    if (mem_wait && !mem_ready_i && state_d == state_q)
      wcnt_d = wcnt_q + 32'd1;
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH &&
        state_q != S_TRAP)
      instret_d = instret_q + CNT_W'(1);
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = RD_RT;
    mem_to_reg_o = M2R_ALU;
    alu_src_a_o  = SA_PC;
    alu_src_b_o  = SB_RT;
    alu_ctrl_o   = ALU_AND;
    pc_src_o     = PCS_ALU;
    if (!rst_i) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SB_FOUR;
          alu_ctrl_o  = ALU_ADD;
          pc_write_o  = mem_ready_i;
          ir_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = SB_IMM2;
          alu_ctrl_o  = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a_o = SA_RS;
          alu_src_b_o = SB_IMM;
          alu_ctrl_o  = ALU_ADD;
        end
        S_MEMRD: begin
          iord_o     = 1'b1;
          mem_read_o = 1'b1;
        end
        S_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_MDR;
        end
        S_MEMWR: begin
          iord_o      = 1'b1;
          mem_write_o = 1'b1;
        end
        S_EXEC: begin
          alu_src_a_o = fn_shift ? SA_SHAMT : SA_RS;
          alu_ctrl_o  = fn_alu;
        end
        S_RWB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = RD_RD;
        end
        S_BRANCH: begin
          alu_src_a_o = SA_RS;
          alu_ctrl_o  = ALU_SUB;
          pc_src_o    = PCS_OUT;
          pc_write_o  = taken;
        end
        S_JUMP: begin
          pc_src_o   = PCS_JMP;
          pc_write_o = 1'b1;
          if (opcode_i == OP_JAL) begin
            reg_write_o  = 1'b1;
            reg_dst_o    = RD_RA;
            mem_to_reg_o = M2R_PC;
          end
        end
        S_IEXEC: begin
          alu_src_a_o = SA_RS;
          alu_src_b_o = SB_IMM;
          alu_ctrl_o  = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_IWB: reg_write_o = 1'b1;
        S_JR: begin
          pc_src_o   = PCS_RS;
          pc_write_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o      = state_q;
  assign trap_o       = (state_q == S_TRAP);
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule
